// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: pipelined, stallable bitwise gate unit.
//
// Each accepted transaction applies one of eight bitwise gate functions to
// WIDTH-bit operands a and b. The result and its zero flag are computed at
// the input and carried through a STAGES-deep pipeline. The pipeline uses
// valid/ready handshakes on both sides, and any bubble inside it is filled
// even while the output is stalled.
//
// Optional feature (macro GATE_UNIT_STATS_EN):
//   txn_count   - saturating count of output transfers.
//   stall_count - saturating count of cycles with out_valid=1 and out_ready=0.
//
// Ports:
//   clk, rst     - rising-edge clock; synchronous active-high reset
//   in_valid     - input transaction present
//   in_ready     - unit accepts input this cycle (combinational from out_ready)
//   in_op        - gate select: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR,
//                  6 XNOR, 7 BUF
//   in_a, in_b   - operands (in_b is ignored for NOT and BUF)
//   out_valid    - result present
//   out_ready    - sink accepts result this cycle
//   out_y        - result
//   out_zero     - out_y is all zeros
//   out_op       - opcode that produced out_y
//   txn_count    - (GATE_UNIT_STATS_EN only) output transfer count
//   stall_count  - (GATE_UNIT_STATS_EN only) output stall cycle count

module gate_unit_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [2:0]       out_op
`ifdef GATE_UNIT_STATS_EN
  ,
  output logic [15:0]      txn_count,
  output logic [15:0]      stall_count
`endif
);

  localparam int unsigned LAST    = STAGES - 1;
  localparam int unsigned CNT_W   = 16;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  // Payload carried by every stage alongside its valid bit.
  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [2:0]       op;
  } payload_t;

  logic [STAGES-1:0] valid_q;
  payload_t          data_q [STAGES];
  logic [STAGES-1:0] adv_c;
  logic [WIDTH-1:0]  gate_y_c;
  payload_t          in_payload_c;

  // Gate function, evaluated at the input.
  always_comb begin
    gate_y_c = '0;
    unique case (in_op)
      OP_NOT:  gate_y_c = ~in_a;
      OP_AND:  gate_y_c = in_a & in_b;
      OP_OR:   gate_y_c = in_a | in_b;
      OP_XOR:  gate_y_c = in_a ^ in_b;
      OP_NAND: gate_y_c = ~(in_a & in_b);
      OP_NOR:  gate_y_c = ~(in_a | in_b);
      OP_XNOR: gate_y_c = ~(in_a ^ in_b);
      OP_BUF:  gate_y_c = in_a;
      default: gate_y_c = '0;
    endcase
  end

  always_comb begin
    in_payload_c      = '0;
    in_payload_c.y    = gate_y_c;
    in_payload_c.zero = (gate_y_c == '0);
    in_payload_c.op   = in_op;
  end

  // Stage i may load when any stage from i to the output is empty, or when
  // the sink takes the last stage. This is the unrolled form of
  // adv[i] = !valid[i] || adv[i+1], written without a self-referencing chain.
  always_comb begin
    logic acc;
    adv_c = '0;
    acc   = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      acc = out_ready;
      for (int unsigned j = i; j < STAGES; j++) begin
        acc = acc | ~valid_q[j];
      end
      adv_c[i] = acc;
    end
  end

  assign in_ready = adv_c[0];

  // Pipeline registers. Payload only loads with a valid entry, so data holds
  // steady when bubbles move through.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (adv_c[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= in_payload_c;
        end
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (adv_c[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_y     = data_q[LAST].y;
  assign out_zero  = data_q[LAST].zero;
  assign out_op    = data_q[LAST].op;

`ifdef GATE_UNIT_STATS_EN
  logic xfer_c;
  logic stall_c;

  assign xfer_c  = out_valid & out_ready;
  assign stall_c = out_valid & ~out_ready;

  // Saturating transfer and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count   <= '0;
      stall_count <= '0;
    end else begin
      if (xfer_c && (txn_count != '1)) begin
        txn_count <= txn_count + CNT_W'(1);
      end
      if (stall_c && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Self-checking bench for gate_unit_pipe (WIDTH=8, STAGES=2).
// Expected results are queued when an input transfer happens and popped by a
// monitor when the DUT presents an output transfer.

module tb_gate_unit_pipe;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic [2:0]       out_op;
`ifdef GATE_UNIT_STATS_EN
  logic [15:0]      txn_count;
  logic [15:0]      stall_count;
`endif

  always #5 clk = ~clk;

  gate_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_op    (out_op)
`ifdef GATE_UNIT_STATS_EN
    ,
    .txn_count   (txn_count),
    .stall_count (stall_count)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [2:0]       op;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pop_cnt  = 0;
  bit   mon_en   = 1'b1;

  // Reference model: per-bit truth table indexed by {a,b}.
  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    logic [3:0] tt;
    exp_t       e;
    case (op)
      3'd0:    tt = 4'b0011;
      3'd1:    tt = 4'b1000;
      3'd2:    tt = 4'b1110;
      3'd3:    tt = 4'b0110;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    e.y = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      e.y[i] = tt[{a[i], b[i]}];
    end
    e.zero = (e.y == '0);
    e.op   = op;
    return e;
  endfunction

  // Output monitor: every output transfer must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && !rst && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got y=%h zero=%0b op=%0d, required no output",
                 out_y, out_zero, out_op);
      end else begin
        e = sb_q.pop_front();
        pop_cnt++;
        if ({out_y, out_zero, out_op} !== e) begin
          failures++;
          $display("FAIL scoreboard: got y=%h zero=%0b op=%0d, required y=%h zero=%0b op=%0d",
                   out_y, out_zero, out_op, e.y, e.zero, e.op);
        end
      end
    end
  end

  // Present one transaction until accepted, queueing its expected result.
  task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input exp_t e);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL drive_timeout: in_ready stayed 0, required 1 within 100 cycles");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100; t++) begin
      if (sb_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (out_y !== 8'h00) begin
      failures++; $display("FAIL reset_out_y: got %h, required 00", out_y);
    end
    checks++;
    if (out_zero !== 1'b0) begin
      failures++; $display("FAIL reset_out_zero: got %b, required 0", out_zero);
    end
    checks++;
    if (out_op !== 3'd0) begin
      failures++; $display("FAIL reset_out_op: got %0d, required 0", out_op);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_single();
    exp_t e;
    e.y = 8'hF0; e.zero = 1'b0; e.op = 3'd0;
    out_ready = 1'b1;
    drive(3'd0, 8'h0F, 8'h00, e);
    for (int c = 1; c <= int'(STAGES); c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == int'(STAGES))) begin
        failures++;
        $display("FAIL single_latency: cycle %0d out_valid=%b, required %b",
                 c, out_valid, (c == int'(STAGES)));
      end
      if (c == int'(STAGES)) begin
        checks++;
        if (out_y !== 8'hF0) begin
          failures++; $display("FAIL single_y: got %h, required F0", out_y);
        end
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_op_sweep();
    logic [WIDTH-1:0] ys [8];
    exp_t e;
    ys[0] = 8'h33; ys[1] = 8'h88; ys[2] = 8'hEE; ys[3] = 8'h66;
    ys[4] = 8'h77; ys[5] = 8'h11; ys[6] = 8'h99; ys[7] = 8'hCC;
    out_ready = 1'b1;
    for (int c = 0; c < 8 + int'(STAGES) + 2; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        in_op    = 3'(c);
        in_a     = 8'hCC;
        in_b     = 8'hAA;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++; $display("FAIL sweep_in_ready: cycle %0d got %b, required 1", c, in_ready);
        end
        e.y = ys[c]; e.zero = 1'b0; e.op = 3'(c);
        if (in_ready) sb_q.push_back(e);
      end
      checks++;
      if (out_valid !== ((c >= int'(STAGES)) && (c < int'(STAGES) + 8))) begin
        failures++;
        $display("FAIL sweep_throughput: cycle %0d out_valid=%b", c, out_valid);
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_zero();
    exp_t e;
    e.y = 8'h00; e.zero = 1'b1; e.op = 3'd1;
    out_ready = 1'b1;
    drive(3'd1, 8'hF0, 8'h0F, e);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] a_v [5];
    logic [2:0]       op_v [5];
    exp_t             held;
    int               idx;
    int               start_pops;
    start_pops = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      a_v[i]  = 8'h3C ^ 8'(i * 17);
      op_v[i] = 3'(i + 2);
    end
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; in_op = op_v[0]; in_a = a_v[0]; in_b = 8'h5A;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_q.push_back(model(op_v[idx], a_v[idx], 8'h5A));
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 5) begin
        in_op = op_v[idx]; in_a = a_v[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (idx != int'(STAGES)) begin
      failures++; $display("FAIL bp_accepted: got %0d, required %0d", idx, STAGES);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_in_ready: got %b, required 0", in_ready);
    end
    held = model(op_v[0], a_v[0], 8'h5A);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {out_y, out_zero, out_op} !== held) begin
        failures++;
        $display("FAIL bp_stable: got v=%b y=%h zero=%b op=%0d, required v=1 y=%h zero=%b op=%0d",
                 out_valid, out_y, out_zero, out_op, held.y, held.zero, held.op);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int t = 0; t < 20 && idx < 5; t++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_q.push_back(model(op_v[idx], a_v[idx], 8'h5A));
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 5) begin
        in_op = op_v[idx]; in_a = a_v[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (pop_cnt - start_pops != 5) begin
      failures++; $display("FAIL bp_count: got %0d results, required 5", pop_cnt - start_pops);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(3'd3, 8'h12, 8'h34, model(3'd3, 8'h12, 8'h34));
    drive(3'd6, 8'h56, 8'h78, model(3'd6, 8'h56, 8'h78));
    // Full pipeline: releasing the sink must accept a new input the same cycle.
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd4; in_a = 8'h9A; in_b = 8'hBC;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL full_shift_accept: in_ready=%b, required 1", in_ready);
    end
    if (in_ready) sb_q.push_back(model(3'd4, 8'h9A, 8'hBC));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(3'd2, 8'hA0, 8'h05, model(3'd2, 8'hA0, 8'h05));
    drive(3'd7, 8'h5B, 8'h00, model(3'd7, 8'h5B, 8'h00));
    rst = 1'b1;
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'hFF; in_b = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_in_ready: got %b, required 1", in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL rst_mid_flushed: cycle %0d out_valid=%b, required 0", c, out_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef GATE_UNIT_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (txn_count !== 16'd0 || stall_count !== 16'd0) begin
      failures++; $display("FAIL stats_reset: txn=%0d stall=%0d, required 0 0", txn_count, stall_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'(i), 8'(i + 1), 8'h0F, model(3'(i), 8'(i + 1), 8'h0F));
    end
    wait_drain();
    checks++;
    if (txn_count !== 16'd3) begin
      failures++; $display("FAIL stats_txn: got %0d, required 3", txn_count);
    end
    out_ready = 1'b0;
    drive(3'd5, 8'h01, 8'h02, model(3'd5, 8'h01, 8'h02));
    for (int t = 0; t < 10 && out_valid !== 1'b1; t++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (stall_count !== 16'd4) begin
      failures++; $display("FAIL stats_stall: got %0d, required 4", stall_count);
    end
    out_ready = 1'b1;
    wait_drain();
    mon_en = 1'b0;
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'h01; in_b = 8'h00;
    repeat (70000) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (txn_count !== 16'hFFFF) begin
      failures++; $display("FAIL stats_saturate: got %h, required FFFF", txn_count);
    end
    sb_q.delete();
    mon_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_op_sweep();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef GATE_UNIT_STATS_EN
    test_stats();
`endif
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gate_unit_pipe.md
Name: gate_unit_pipe

Overview:
- Parametrised, pipelined bitwise gate unit; next generation of the single-bit NOT gate.
- Applies one of eight gate functions, selected per transaction, across WIDTH-bit operands a and b.
- Results pass through a STAGES-deep stallable pipeline with valid/ready handshakes on input and output.
- Sits between a stimulus source and any sink that may apply backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- STAGES, 2, pipeline depth; legal range 1..4; equals minimum latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input transaction present.
- in_ready  output  1  unit can accept input this cycle.
- in_op  input  3  gate function select.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b; ignored for NOT and BUF.
- out_valid  output  1  result present.
- out_ready  input  1  sink accepts result this cycle.
- out_y  output  WIDTH  result.
- out_zero  output  1  high when out_y is all zeros.
- out_op  output  3  opcode that produced out_y.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Opcodes: 000 NOT a; 001 a AND b; 010 a OR b; 011 a XOR b; 100 NAND; 101 NOR; 110 XNOR; 111 BUF a.
- Functions are bitwise and strictly per bit; no carries, no width change.
- Result computation: the gate result and zero flag are computed combinationally at input and captured into stage 0.
- Stage contents: each later stage holds a copy; each stage carries valid, y, zero and op.
- Input handshake: transfer occurs when in_valid and in_ready are both high at a clk edge.
- Output handshake: transfer occurs when out_valid and out_ready are both high at a clk edge.
- Stage advance: stage i loads from stage i-1 (stage 0 from input) when stage i is empty, or when stage i's own contents move on that cycle.
  - The last stage moves on when out_ready is high.
  - A bubble anywhere is filled even while the output is stalled.
- in_ready: equals stage-0 advance condition; it is combinational from out_ready through the chain.
- Latency: exactly STAGES cycles from input transfer to out_valid when unstalled.
- Throughput: 1 transaction per cycle.
- Output stability: while out_valid is high and out_ready is low, out_y, out_zero and out_op hold stable, and no transaction is lost or duplicated.
- Ordering: results emerge in strict input order.
- Capacity: with out_ready low, at most STAGES transactions are accepted, after which in_ready goes low.
- Simultaneous events: when full and out_ready is high, the pipeline shifts and accepts a new input in the same cycle.
- Reset values: all stage valids 0, so out_valid=0; out_y=0, out_zero=0, out_op=0.
  - in_ready follows the advance logic and is 1 in the cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded; a transfer presented during the reset cycle is not accepted.
- in_valid low: no state change other than draining.

Optional Feature:
- Macro GATE_UNIT_STATS_EN.
- When defined:
  - Adds output port txn_count (16 bits), counting output transfers.
  - Increments by 1 per transfer and saturates at 16'hFFFF.
  - Reset value 0.
  - Adds output port stall_count (16 bits), counting cycles with out_valid=1 and out_ready=0; saturating, reset 0.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then single transaction with WIDTH=8, STAGES=2, op=000, a=8'h0F, out_ready=1.
  - Required: out_valid high exactly 2 cycles after transfer, out_y=8'hF0, out_zero=0, out_op=000.
- Sweep all 8 ops with a=8'hCC, b=8'hAA back-to-back.
  - Required: y = 33, 88, EE, 66, 77, 11, 99, CC, in order; one result per cycle.
- op=001, a=8'hF0, b=8'h0F.
  - Required: out_y=8'h00, out_zero=1.
- Hold out_ready=0 and stream 5 inputs.
  - Required: exactly 2 accepted; in_ready=0 thereafter; out_y stable.
  - Then raise out_ready: the 2 results emerge in order, then the remaining 3, with no loss and no duplication.
- Assert rst for one cycle while 2 transactions are in flight.
  - Required: out_valid=0 the next cycle; neither result is ever emitted.
- With GATE_UNIT_STATS_EN defined: 3 transfers plus 4 stall cycles.
  - Required: txn_count=3, stall_count=4.
  - Force 70000 transfers: txn_count saturates at 16'hFFFF.
